// File: rtl/muladd_stream_if.sv
// Operand/result stream bundle for muladd_stream: term side (A, B, C, modes,
// len, clr, valid/ready) and result side (Q, Q_ovf, valid/ready).
interface muladd_stream_if #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int C_WIDTH   = 20,
  parameter int Q_WIDTH   = 24,
  parameter int LEN_WIDTH = 8
) ();
  logic                 clr;
  logic                 signExtension;
  logic                 SAT;
  logic [LEN_WIDTH-1:0] len;
  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic [C_WIDTH-1:0]   C;
  logic                 in_valid;
  logic                 in_ready;
  logic [Q_WIDTH-1:0]   Q;
  logic                 Q_ovf;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output clr, signExtension, SAT, len, A, B, C, in_valid, out_ready,
    input  in_ready, Q, Q_ovf, out_valid
  );
  modport slave (
    input  clr, signExtension, SAT, len, A, B, C, in_valid, out_ready,
    output in_ready, Q, Q_ovf, out_valid
  );
endinterface

// File: rtl/muladd_stream.sv
// Three-stage streaming dot-product MAC: S1 operand capture, S2 multiply,
// S3 accumulate (seeded from C on the first term) with optional saturation.
module muladd_stream #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int C_WIDTH   = 20,
  parameter int Q_WIDTH   = 24,
  parameter int LEN_WIDTH = 8
) (
  input logic           CLK,
  input logic           RESETn,
  muladd_stream_if.slave bus
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int S_WIDTH = Q_WIDTH + 1;

  typedef struct packed {
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic [C_WIDTH-1:0] c;
    logic first, last, sgn, sat;
  } s1_t;

  typedef struct packed {
    logic [P_WIDTH-1:0] m;
    logic [C_WIDTH-1:0] c;
    logic first, last, sgn, sat;
  } s2_t;

  s1_t s1;
  s2_t s2;
  logic [1:0] vld_pipe;

  logic [LEN_WIDTH-1:0] cnt, len_h, len_eff;
  logic sgn_h, sat_h, sgn_cur, sat_cur;
  logic stall, accept, is_first, is_last;

  logic [Q_WIDTH-1:0] acc, q_r;
  logic ovf_acc, qovf_r, out_valid_r;

  assign stall        = out_valid_r & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign bus.Q        = q_r;
  assign bus.Q_ovf    = qovf_r;
  assign bus.out_valid = out_valid_r;

  assign accept   = bus.in_valid & ~stall & ~bus.clr;
  assign is_first = (cnt == '0);
  // Modes and length come live from the bus on the first term, from the held copy afterwards.
  assign len_eff  = is_first ? ((bus.len == '0) ? LEN_WIDTH'(1) : bus.len) : len_h;
  assign sgn_cur  = is_first ? bus.signExtension : sgn_h;
  assign sat_cur  = is_first ? bus.SAT : sat_h;
  assign is_last  = (cnt == len_eff - 1'b1);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt   <= '0;
      len_h <= '0;
      sgn_h <= 1'b0;
      sat_h <= 1'b0;
    end else if (bus.clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= is_last ? '0 : cnt + 1'b1;
      if (is_first) begin
        len_h <= len_eff;
        sgn_h <= sgn_cur;
        sat_h <= sat_cur;
      end
    end
  end

  // Low P_WIDTH bits of the product of sign-extended operands equal the signed product.
  logic [P_WIDTH-1:0] prod_s, prod_u;
  assign prod_s = P_WIDTH'($signed(s1.a)) * P_WIDTH'($signed(s1.b));
  assign prod_u = P_WIDTH'(s1.a) * P_WIDTH'(s1.b);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else if (bus.clr) begin
      vld_pipe <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[0], accept};
      s1 <= '{bus.A, bus.B, bus.C, is_first, is_last, sgn_cur, sat_cur};
      s2 <= '{(s1.sgn ? prod_s : prod_u), s1.c, s1.first, s1.last, s1.sgn, s1.sat};
    end
  end

  logic [S_WIDTH-1:0] m_ext, c_ext, a_ext, sum;
  logic [Q_WIDTH-1:0] clamp, result;
  logic ovf, ovf_new, land_last;

  always_comb begin
    m_ext = s2.sgn ? {{(S_WIDTH-P_WIDTH){s2.m[P_WIDTH-1]}}, s2.m}
                   : {{(S_WIDTH-P_WIDTH){1'b0}}, s2.m};
    c_ext = s2.sgn ? {{(S_WIDTH-C_WIDTH){s2.c[C_WIDTH-1]}}, s2.c}
                   : {{(S_WIDTH-C_WIDTH){1'b0}}, s2.c};
    a_ext = {s2.sgn & acc[Q_WIDTH-1], acc};
    sum   = (s2.first ? c_ext : a_ext) + m_ext;
    // Signed: the extra bit disagrees with the Q-width sign bit. Unsigned: carry out.
    ovf   = s2.sgn ? (sum[Q_WIDTH] ^ sum[Q_WIDTH-1]) : sum[Q_WIDTH];
    if (!s2.sgn)         clamp = '1;
    else if (sum[Q_WIDTH]) clamp = {1'b1, {(Q_WIDTH-1){1'b0}}};
    else                 clamp = {1'b0, {(Q_WIDTH-1){1'b1}}};
    result  = (s2.sat & ovf) ? clamp : sum[Q_WIDTH-1:0];
    ovf_new = (~s2.first & ovf_acc) | ovf;
  end

  assign land_last = vld_pipe[1] & s2.last & ~bus.clr;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (bus.clr) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (!stall && vld_pipe[1]) begin
      acc     <= result;
      ovf_acc <= ovf_new;
    end
  end

  // Not stalled means the held result (if any) is being taken this edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid_r <= 1'b0;
      q_r         <= '0;
      qovf_r      <= 1'b0;
    end else if (!stall) begin
      out_valid_r <= land_last;
      if (land_last) begin
        q_r    <= result;
        qovf_r <= ovf_new;
      end
    end
  end
endmodule

// File: tb/tb_muladd_stream.sv
// Directed + randomized bench for muladd_stream against an integer dot-product model.
module tb_muladd_stream;
  logic CLK = 1'b0;
  logic RESETn;
  always #5 CLK = ~CLK;

  // C widened to the full accumulator width so 24-bit seeds such as 8388000 fit.
  muladd_stream_if #(.A_WIDTH(8), .B_WIDTH(8), .C_WIDTH(24), .Q_WIDTH(24), .LEN_WIDTH(8)) bus ();

  muladd_stream #(.A_WIDTH(8), .B_WIDTH(8), .C_WIDTH(24), .Q_WIDTH(24), .LEN_WIDTH(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .bus(bus)
  );

  int errs = 0;
  int checks = 0;
  int stall_cycles = 0;
  logic [7:0]  ta [16];
  logic [7:0]  tb [16];
  logic [24:0] expq [$];
  logic [24:0] obsq [$];

  // Results are taken at the next rising edge when valid & ready hold here.
  always @(negedge CLK)
    if (RESETn && bus.out_valid && bus.out_ready) obsq.push_back({bus.Q_ovf, bus.Q});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Dot product by plain integer arithmetic, clamping or wrapping after each term.
  function automatic logic [24:0] model(input bit sgn, input bit sat, input int n, input logic [23:0] c);
    longint acc, lo, hi, av, bv;
    bit ovf;
    ovf = 1'b0;
    lo  = sgn ? -(longint'(1) << 23) : 0;
    hi  = sgn ? (longint'(1) << 23) - 1 : (longint'(1) << 24) - 1;
    acc = sgn ? longint'($signed(c)) : longint'(c);
    for (int i = 0; i < n; i++) begin
      av  = sgn ? longint'($signed(ta[i])) : longint'(ta[i]);
      bv  = sgn ? longint'($signed(tb[i])) : longint'(tb[i]);
      acc = acc + av * bv;
      if (acc < lo || acc > hi) begin
        ovf = 1'b1;
        if (sat) acc = (acc < lo) ? lo : hi;
        else begin
          acc = acc & 64'hFF_FFFF;
          if (sgn && acc > hi) acc = acc - (longint'(1) << 24);
        end
      end
    end
    return {ovf, acc[23:0]};
  endfunction

  task automatic send_term(input logic [7:0] a, input logic [7:0] b, input logic [23:0] c,
                           input logic [7:0] ln, input bit sgn, input bit sat, input bit bp);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    bus.A = a; bus.B = b; bus.C = c; bus.len = ln;
    bus.signExtension = sgn; bus.SAT = sat; bus.in_valid = 1'b1;
    while (!done && t < 200) begin
      if (bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      done = bus.in_ready;
      if (!done) stall_cycles++;
      @(posedge CLK);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    chk("accept", 64'(done), 64'd1);
  endtask

  // Non-first terms carry junk C and, with noise, junk len/modes that must be ignored.
  task automatic run_prod(input bit sgn, input bit sat, input int ln, input logic [23:0] c,
                          input bit bp, input bit noise);
    int n;
    n = (ln == 0) ? 1 : ln;
    for (int i = 0; i < n; i++) begin
      if (i == 0)     send_term(ta[i], tb[i], c, 8'(ln), sgn, sat, bp);
      else if (noise) send_term(ta[i], tb[i], 24'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), bp);
      else            send_term(ta[i], tb[i], 24'($urandom), 8'(ln), sgn, sat, bp);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    logic [24:0] o, e;
    t = 0;
    bus.out_ready = 1'b1;
    while (obsq.size() < expq.size() && t < 500) begin
      @(posedge CLK);
      #1;
      t++;
    end
    repeat (4) @(posedge CLK);
    #1;
    chk({tag, "_count"}, 64'(obsq.size()), 64'(expq.size()));
    while (obsq.size() > 0 && expq.size() > 0) begin
      o = obsq.pop_front();
      e = expq.pop_front();
      chk({tag, "_Q"}, 64'(o[23:0]), 64'(e[23:0]));
      chk({tag, "_ovf"}, 64'(o[24]), 64'(e[24]));
    end
    obsq.delete();
    expq.delete();
  endtask

  initial begin
    bus.clr = 1'b0; bus.signExtension = 1'b0; bus.SAT = 1'b0; bus.len = '0;
    bus.A = '0; bus.B = '0; bus.C = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    RESETn = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_Q", 64'(bus.Q), 64'd0);
    chk("rst_Q_ovf", 64'(bus.Q_ovf), 64'd0);
    repeat (2) @(posedge CLK);
    #2 RESETn = 1'b1;
    @(posedge CLK);
    #1;

    // Unsigned len=1 with cycle-exact latency.
    bus.A = 8'd3; bus.B = 8'd5; bus.C = 24'd10; bus.len = 8'd1;
    bus.signExtension = 1'b0; bus.SAT = 1'b0; bus.in_valid = 1'b1;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    chk("lat_E0_valid", 64'(bus.out_valid), 64'd0);
    @(posedge CLK); #1;
    chk("lat_E1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge CLK); #1;
    chk("lat_E2_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_E2_Q", 64'(bus.Q), 64'd25);
    chk("lat_E2_ovf", 64'(bus.Q_ovf), 64'd0);
    @(posedge CLK); #1;
    chk("lat_E3_valid", 64'(bus.out_valid), 64'd0);
    obsq.delete();

    // Back-to-back signed products with no bubble.
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin ta[i] = 8'hFE; tb[i] = 8'd3; end
    expq.push_back({1'b0, 24'd76});
    run_prod(1'b1, 1'b0, 4, 24'd100, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin ta[i] = 8'd1; tb[i] = 8'd1; end
    expq.push_back({1'b0, 24'd2});
    run_prod(1'b1, 1'b0, 2, 24'd0, 1'b0, 1'b0);
    chk("b2b_no_bubble", 64'(stall_cycles), 64'd0);
    drain("b2b");

    // Signed overflow: saturate then wrap.
    ta[0] = 8'd127; tb[0] = 8'd127;
    expq.push_back({1'b1, 24'h7FFFFF});
    run_prod(1'b1, 1'b1, 1, 24'd8388000, 1'b0, 1'b0);
    expq.push_back({1'b1, 24'h803CA1});
    run_prod(1'b1, 1'b0, 1, 24'd8388000, 1'b0, 1'b0);
    drain("ovf");

    // Backpressure: three results queued behind out_ready=0.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [23:0] c;
      ta[0] = 8'($urandom); tb[0] = 8'($urandom); c = 24'($urandom);
      expq.push_back(model(1'b0, 1'b0, 1, c));
      run_prod(1'b0, 1'b0, 1, c, 1'b0, 1'b0);
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_none_taken", 64'(obsq.size()), 64'd0);
    drain("bp");

    // clr aborts a partial len=4 product; the term offered with clr is dropped.
    ta[0] = 8'd9; tb[0] = 8'd9; ta[1] = 8'd9; tb[1] = 8'd9;
    send_term(ta[0], tb[0], 24'd500, 8'd4, 1'b0, 1'b0, 1'b0);
    send_term(ta[1], tb[1], 24'd0, 8'd4, 1'b0, 1'b0, 1'b0);
    bus.clr = 1'b1; bus.in_valid = 1'b1; bus.A = 8'd50; bus.B = 8'd50;
    @(posedge CLK); #1;
    bus.clr = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("clr_no_result", 64'(obsq.size()), 64'd0);
    for (int i = 0; i < 4; i++) begin ta[i] = 8'd1; tb[i] = 8'd1; end
    expq.push_back({1'b0, 24'd11});
    run_prod(1'b0, 1'b0, 4, 24'd7, 1'b0, 1'b0);
    drain("clr");

    // Asynchronous reset with a result held and a product in flight.
    bus.out_ready = 1'b0;
    send_term(8'd7, 8'd7, 24'd3, 8'd1, 1'b0, 1'b0, 1'b0);
    send_term(8'd5, 8'd5, 24'd3, 8'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    #2 RESETn = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_Q", 64'(bus.Q), 64'd0);
    chk("ar_Q_ovf", 64'(bus.Q_ovf), 64'd0);
    chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK);
    #1 RESETn = 1'b1;
    obsq.delete();
    expq.delete();
    bus.out_ready = 1'b1;
    ta[0] = 8'd2; tb[0] = 8'd2;
    expq.push_back({1'b0, 24'd4});
    run_prod(1'b0, 1'b0, 1, 24'd0, 1'b0, 1'b0);
    drain("ar");

    // Random products, random backpressure, junk modes/len on non-first terms.
    for (int k = 0; k < 25; k++) begin
      bit sgn, sat;
      int ln;
      logic [23:0] c;
      sgn = 1'($urandom); sat = 1'($urandom);
      ln = $urandom_range(0, 5);
      c = 24'($urandom);
      for (int i = 0; i < 16; i++) begin ta[i] = 8'($urandom); tb[i] = 8'($urandom); end
      expq.push_back(model(sgn, sat, (ln == 0) ? 1 : ln, c));
      run_prod(sgn, sat, ln, c, 1'b1, 1'b1);
    end
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
